// File: rtl/dff_pipe_array.sv
// dff_pipe_array: parameterised delay line for a 2-D array of words.
// PIPE_DEPTH register stages, async active-high clear, shared enable.
module dff_pipe_array #(
    parameter int WIDTH         = 24,
    parameter int ARRAY_SIZE1   = 3,
    parameter int ARRAY_SIZE2   = 3,
    parameter int PIPE_DEPTH    = 3,
    parameter int RETIME_STATUS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0],
    output logic [WIDTH-1:0] out [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0]
);

    // Retiming is a synthesis permission only; it never changes behaviour.
    logic unused_retime;
    assign unused_retime = (RETIME_STATUS != 0);

    if (PIPE_DEPTH == 0) begin : g_wire

        // Clock, reset and enable have nothing to act on at zero depth.
        logic unused_ctl;
        assign unused_ctl = clk ^ reset ^ en;

        // Zero depth: a plain wire from input to output.
        always_comb begin
            for (int i = 0; i < ARRAY_SIZE1; i++) begin
                for (int j = 0; j < ARRAY_SIZE2; j++) begin
                    out[i][j] = in[i][j];
                end
            end
        end

    end else begin : g_pipe

        logic [WIDTH-1:0] stage_q [PIPE_DEPTH-1:0]
                                  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0];
        logic [WIDTH-1:0] stage_d [PIPE_DEPTH-1:0]
                                  [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0];

        // Shifted view: stage 0 takes the input, each later stage its
        // predecessor.
        always_comb begin
            for (int i = 0; i < ARRAY_SIZE1; i++) begin
                for (int j = 0; j < ARRAY_SIZE2; j++) begin
                    stage_d[0][i][j] = in[i][j];
                end
            end
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                for (int i = 0; i < ARRAY_SIZE1; i++) begin
                    for (int j = 0; j < ARRAY_SIZE2; j++) begin
                        stage_d[k][i][j] = stage_q[k-1][i][j];
                    end
                end
            end
        end

        // Stage registers: async clear wins, otherwise shift when enabled.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    for (int i = 0; i < ARRAY_SIZE1; i++) begin
                        for (int j = 0; j < ARRAY_SIZE2; j++) begin
                            stage_q[k][i][j] <= '0;
                        end
                    end
                end
            end else if (en) begin
                for (int k = 0; k < PIPE_DEPTH; k++) begin
                    for (int i = 0; i < ARRAY_SIZE1; i++) begin
                        for (int j = 0; j < ARRAY_SIZE2; j++) begin
                            stage_q[k][i][j] <= stage_d[k][i][j];
                        end
                    end
                end
            end
        end

        // Output is taken straight from the last register stage.
        always_comb begin
            for (int i = 0; i < ARRAY_SIZE1; i++) begin
                for (int j = 0; j < ARRAY_SIZE2; j++) begin
                    out[i][j] = stage_q[PIPE_DEPTH-1][i][j];
                end
            end
        end

    end

endmodule

// File: tb/tb_dff_pipe_array.sv
// tb_dff_pipe_array: scoreboard bench for dff_pipe_array.
// Reference model: output is the DEPTH-th most recent enabled input.
`timescale 1ns/1ps
module tb_dff_pipe_array;

    localparam int W     = 24;
    localparam int DEPTH = 3;
    localparam int VW    = 9 * W;

    typedef logic [W-1:0] arr_t [2:0][2:0];

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic   en_a = 1'b0;
    arr_t   in_a;
    arr_t   out_a;
    arr_t   out_b;

    logic          en_c = 1'b0;
    logic [W-1:0]  in_c  [0:0][0:0];
    logic [W-1:0]  out_c [0:0][0:0];

    logic [W-1:0]  in_d  [0:0][0:0];
    logic [W-1:0]  out_d [0:0][0:0];

    logic          en_e = 1'b0;
    logic [W-1:0]  in_e  [1:0][0:0];
    logic [W-1:0]  out_e [1:0][0:0];

    int tests = 0;
    int fails = 0;

    arr_t            seen  [$];
    logic [VW-1:0]   exp_q [$];
    logic [VW-1:0]   mon_want;

    always #5 clk = ~clk;

    dff_pipe_array #(
        .WIDTH(W), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3),
        .PIPE_DEPTH(DEPTH), .RETIME_STATUS(0)
    ) u_a (
        .clk(clk), .reset(reset), .en(en_a), .in(in_a), .out(out_a)
    );

    dff_pipe_array #(
        .WIDTH(W), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3),
        .PIPE_DEPTH(DEPTH), .RETIME_STATUS(1)
    ) u_b (
        .clk(clk), .reset(reset), .en(en_a), .in(in_a), .out(out_b)
    );

    dff_pipe_array #(
        .WIDTH(W), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1),
        .PIPE_DEPTH(3), .RETIME_STATUS(0)
    ) u_c (
        .clk(clk), .reset(reset), .en(en_c), .in(in_c), .out(out_c)
    );

    dff_pipe_array #(
        .WIDTH(W), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1),
        .PIPE_DEPTH(0), .RETIME_STATUS(0)
    ) u_d (
        .clk(clk), .reset(reset), .en(1'b1), .in(in_d), .out(out_d)
    );

    dff_pipe_array #(
        .WIDTH(W), .ARRAY_SIZE1(2), .ARRAY_SIZE2(1),
        .PIPE_DEPTH(1), .RETIME_STATUS(0)
    ) u_e (
        .clk(clk), .reset(reset), .en(en_e), .in(in_e), .out(out_e)
    );

    function automatic logic [VW-1:0] pack(input arr_t a);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                v[(i*3+j)*W +: W] = a[i][j];
        return v;
    endfunction

    function automatic arr_t fill(input logic [W-1:0] x);
        arr_t a;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = x;
        return a;
    endfunction

    function automatic arr_t rnd();
        arr_t a;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                a[i][j] = W'($urandom);
        return a;
    endfunction

    function automatic logic [VW-1:0] model_out();
        if (seen.size() < DEPTH) return '0;
        return pack(seen[seen.size() - DEPTH]);
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] got,
                       input logic [VW-1:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // One clock step of the main stream; expected output is queued.
    task automatic step(input arr_t a, input logic e, input logic r);
        @(negedge clk);
        in_a  = a;
        en_a  = e;
        reset = r;
        if (r) begin
            seen.delete();
        end else if (e) begin
            seen.push_back(a);
            if (seen.size() > DEPTH) void'(seen.pop_front());
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: compare both wide DUTs after every edge with a pending entry.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                mon_want = exp_q.pop_front();
                chk("sb_a", pack(out_a), mon_want);
                chk("sb_b_retime", pack(out_b), mon_want);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "timeout");
    end

    logic [W-1:0] c_in  [8] = '{1, 2, 3, 7, 7, 7, 7, 7};
    logic         c_en  [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    logic [W-1:0] c_exp [8] = '{0, 0, 1, 1, 1, 2, 3, 7};

    initial begin
        arr_t a;
        in_a       = fill('0);
        in_c[0][0] = '0;
        in_d[0][0] = '0;
        in_e[0][0] = '0;
        in_e[1][0] = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_a", pack(out_a), '0);
        chk("rst_b", pack(out_b), '0);
        chk("rst_c", VW'(out_c[0][0]), '0);
        chk("rst_e", VW'({out_e[1][0], out_e[0][0]}), '0);
        step(fill('0), 1'b1, 1'b1);
        step(fill('0), 1'b1, 1'b1);

        // Indexed stream with en held high.
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    a[i][j] = W'(16 * c + 3 * i + j);
            step(a, 1'b1, 1'b0);
        end

        // Fill with a constant, then reset between edges.
        for (int c = 0; c < 3; c++) step(fill(24'hABCDEF), 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        seen.delete();
        #1;
        chk("async_rst_a", pack(out_a), '0);
        chk("async_rst_b", pack(out_b), '0);
        exp_q.push_back('0);
        for (int c = 0; c < 3; c++) step(fill(24'd5), 1'b1, 1'b0);

        // Random data, random enable, rare resets.
        for (int c = 0; c < 1000; c++)
            step(rnd(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0));

        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0)
            chk("sb_drain", VW'(exp_q.size()), '0);

        // Scalar stall sequence.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            reset      = 1'b0;
            in_c[0][0] = c_in[k];
            en_c       = c_en[k];
            @(posedge clk);
            #2;
            chk($sformatf("stall_%0d", k), VW'(out_c[0][0]),
                VW'(c_exp[k]));
        end

        // Zero depth: pure wire, insensitive to clock and reset.
        @(negedge clk);
        in_d[0][0] = 24'h123456;
        #1 chk("d0_wire", VW'(out_d[0][0]), VW'(24'h123456));
        reset = 1'b1;
        #1 chk("d0_rst", VW'(out_d[0][0]), VW'(24'h123456));
        @(posedge clk);
        #1 chk("d0_clk", VW'(out_d[0][0]), VW'(24'h123456));
        reset = 1'b0;
        in_d[0][0] = 24'h00FF00;
        #1 chk("d0_chg", VW'(out_d[0][0]), VW'(24'h00FF00));

        // Depth 1, extreme bit patterns in separate elements.
        @(negedge clk);
        in_e[0][0] = 24'h800000;
        in_e[1][0] = 24'h7FFFFF;
        en_e       = 1'b1;
        #1 chk("e_pre", VW'({out_e[1][0], out_e[0][0]}), '0);
        @(posedge clk);
        #2;
        chk("e_msb", VW'(out_e[0][0]), VW'(24'h800000));
        chk("e_max", VW'(out_e[1][0]), VW'(24'h7FFFFF));
        @(negedge clk);
        in_e[0][0] = 24'h7FFFFF;
        in_e[1][0] = 24'h800000;
        @(posedge clk);
        #2;
        chk("e_swap", VW'({out_e[1][0], out_e[0][0]}),
            VW'({24'h800000, 24'h7FFFFF}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_pipe_array.md
DFF_PIPE_ARRAY -- requirements
Module: dff_pipe_array

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning bits per element.
REQ-002 The block SHALL have parameter ARRAY_SIZE1, default 3, meaning outer array dimension (1 for scalar or 1-D use).
REQ-003 The block SHALL have parameter ARRAY_SIZE2, default 3, meaning inner array dimension (1 for scalar use).
REQ-004 The block SHALL have parameter PIPE_DEPTH, default 3, meaning number of register stages (0 allowed).
REQ-005 The block SHALL have parameter RETIME_STATUS, default 0, meaning retiming permission flag (0 = no retime, 1 = retime allowed).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all stages update on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port en, input, 1 bit: shift enable for all stages.
REQ-009 The block SHALL have port in, input, unpacked [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0] of logic [WIDTH-1:0]: the data to delay.
REQ-010 The block SHALL have port out, output, same shape as in: the delayed data.

Function
REQ-011 The block SHALL hold PIPE_DEPTH stages; each stage stores a full ARRAY_SIZE1 x ARRAY_SIZE2 x WIDTH copy.
REQ-012 On a rising clk edge with en=1 and reset=0, stage 0 SHALL load in and stage k SHALL load stage k-1, for k = 1..PIPE_DEPTH-1.
REQ-013 On a rising clk edge with en=0 and reset=0, every stage SHALL hold its value.
REQ-014 out SHALL equal the last stage, so with en held at 1 the latency is exactly PIPE_DEPTH clock edges.
REQ-015 With PIPE_DEPTH=0, out SHALL equal in combinationally, and no registers SHALL be inferred.
REQ-016 Each element and bit SHALL be passed unmodified: no sign extension, no arithmetic, and signed or unsigned interpretation is left to the user.
REQ-017 Elements SHALL be independent, with no reordering across array indices.
REQ-018 RETIME_STATUS SHALL have no functional effect; value 1 only permits synthesis register retiming and value 0 forbids it.
REQ-019 Outputs SHALL be glitch-free registered values whenever PIPE_DEPTH >= 1.
REQ-020 ARRAY_SIZE1=1 and ARRAY_SIZE2=1 SHALL give plain scalar delay behaviour, and ARRAY_SIZE2=1 SHALL give 1-D array behaviour.

Reset
REQ-021 While reset=1, every element of every stage SHALL be 0 immediately, without waiting for clk, and out SHALL be 0 (for PIPE_DEPTH >= 1).
REQ-022 Reset SHALL take priority over en and clk.
REQ-023 A reset asserted mid-operation SHALL discard all in-flight data.
REQ-024 After reset deasserts, out SHALL remain 0 until the first post-reset input has traversed PIPE_DEPTH enabled edges.
REQ-025 Reset deassertion SHALL be clean at the next rising edge: the first edge with reset=0 and en=1 loads stage 0.

Verification
REQ-026 Depth-3 stream: WIDTH=24, sizes 3x3, en=1; drive in[i][j] = 16*cycle + 3*i + j -> out equals the value driven 3 edges earlier, every element.
REQ-027 Enable stall: depth 3, scalar; drive 1, 2, 3, then en=0 for 2 edges while in=7, then en=1 -> out holds 1 during the stall and then continues 2, 3, 7.
REQ-028 Async reset mid-stream: depth 3 full of 0xABCDEF; assert reset between edges -> out=0 within the same timestep; after release with in=5 and en=1 -> out=0 for 2 edges, then 5 on the 3rd edge.
REQ-029 Zero depth: PIPE_DEPTH=0, in=0x123456 -> out=0x123456 in the same timestep, unaffected by clk and reset.
REQ-030 Sign/width integrity: WIDTH=24, in=0x800000 and 0x7FFFFF in different elements, depth 1 -> out has exactly those bit patterns after 1 edge.
REQ-031 RETIME_STATUS=1 versus 0 on the same random stimulus (1000 cycles, random en) -> identical out traces.
